// File: rtl/data_mem_bank_if.sv
// data_mem_bank_if: request/response bus of the data memory bank.
//   master : req, cs_n, we, size, sext, addr, wdata   -> bank
//   slave  : busy, ready, rdata, err                  -> requester
// size: 00 byte, 01 halfword, 10/11 word. wdata is right-aligned.
interface data_mem_bank_if;
    logic        req;
    logic        cs_n;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, cs_n, we, size, sext, addr, wdata,
        input  busy, ready, rdata, err
    );

    modport slave (
        input  req, cs_n, we, size, sext, addr, wdata,
        output busy, ready, rdata, err
    );
endinterface

// File: rtl/data_mem_bank.sv
// data_mem_bank: single-port byte-addressable data memory with a
// serialised request/response handshake.
//   clk  : single clock, all state on the rising edge
//   rst  : asynchronous, active-low reset (storage is not cleared)
//   bus  : data_mem_bank_if.slave (req/cs_n/we/size/sext/addr/wdata in,
//          busy/ready/rdata/err out)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, 16..2^18)
//   WAIT_STATES : extra cycles between acceptance and response (0..7)
// Build option:
//   DMEM_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses
//   respond with err=1, rdata=0 and no store. When undefined, the low
//   address bits are forced to alignment and the access completes.
// An access is accepted on a rising edge with req=1, cs_n=0, busy=0.
// ready pulses for one cycle WAIT_STATES+1 cycles after acceptance; the
// store (if any) is committed at the end of that response cycle.
module data_mem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_bank_if.slave   bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Only the byte offset within the bank is kept; higher bits wrap.
    localparam int BA = AW + 2;
    localparam logic [2:0] WCNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic [BA-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            sext_q, sext_d;
    logic [31:0]     wdata_q, wdata_d;

    logic            accept;
    logic [BA-1:0]   eff_addr;
    logic            trap;
    logic [AW-1:0]   idx;
    logic [1:0]      off;
    logic [31:0]     rd_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_val;
    logic [3:0]      be;
    logic [31:0]     wr_lane;
    logic            wr_en;
    logic            resp;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            addr_hi_unused;
    assign addr_hi_unused = ^bus.addr[31:BA];

    assign accept = bus.req & ~bus.cs_n & (state_q == S_IDLE);
    assign resp   = (state_q == S_RESP);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                    wcnt_d  = WCNT_INIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Request capture
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            wdata_q <= 32'd0;
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d  = bus.addr[BA-1:0];
            we_d    = bus.we;
            size_d  = bus.size;
            sext_d  = bus.sext;
            wdata_d = bus.wdata;
        end
    end

    // ---------------------------------------------------------------
    // Alignment handling
    // ---------------------------------------------------------------
`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;
    always_comb begin
        unique case (size_q)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_q[0];
            default: misaligned = (addr_q[1:0] != 2'b00);
        endcase
    end
    assign eff_addr = addr_q;
    assign trap     = misaligned;
`else
    always_comb begin
        unique case (size_q)
            2'b00:   eff_addr = addr_q;
            2'b01:   eff_addr = {addr_q[BA-1:1], 1'b0};
            default: eff_addr = {addr_q[BA-1:2], 2'b00};
        endcase
    end
    assign trap = 1'b0;
`endif

    assign idx     = eff_addr[BA-1:2];
    assign off     = eff_addr[1:0];
    assign rd_word = mem[idx];

    // ---------------------------------------------------------------
    // Load path: little-endian lane select, then sign/zero extend
    // ---------------------------------------------------------------
    always_comb begin
        ld_byte = rd_word[{off, 3'b000} +: 8];
        ld_half = off[1] ? rd_word[31:16] : rd_word[15:0];
        unique case (size_q)
            2'b00:   ld_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{sext_q & ld_half[15]}}, ld_half};
            default: ld_val = rd_word;
        endcase
    end

    // ---------------------------------------------------------------
    // Store path: replicate right-aligned data across lanes, enable
    // only the lanes being written.
    // ---------------------------------------------------------------
    always_comb begin
        unique case (size_q)
            2'b00: begin
                be      = 4'b0001 << off;
                wr_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{wdata_q[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_lane = wdata_q;
            end
        endcase
    end

    // resp is already forced low by reset; the rst term also blocks a
    // commit on an edge that coincides with reset assertion.
    assign wr_en = resp & we_q & ~trap & rst;

    // Storage has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wr_lane[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        bus.busy  = (state_q != S_IDLE);
        bus.ready = resp;
        bus.err   = resp & trap;
        bus.rdata = (resp & ~we_q & ~trap) ? ld_val : 32'd0;
    end

endmodule
